// File: rtl/mem_burst_initiator.sv
// Burst initiator: converts one command into single-word requests on a memory target port,
// with credit-limited reads and a registered-head response FIFO.
// Build option MEM_BURST_ADDR_CHECK_EN: check returned s_addr against issued addresses (sticky err).
module mem_burst_initiator #(
   parameter int MAX_OUTST = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [11:0] cmd_addr,
   input  logic [12:0] cmd_len,
   input  logic        wd_valid,
   output logic        wd_ready,
   input  logic [31:0] wd_data,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic [31:0] rd_data,
   output logic        rd_last,
   output logic [11:0] m_addr,
   output logic [31:0] m_data,
   output logic        m_we,
   output logic        m_valid,
   input  logic        m_ready,
   input  logic [11:0] s_addr,
   input  logic [31:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int PTR_W = $clog2(MAX_OUTST);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(MAX_OUTST);

   typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
   state_t state, state_nxt;

   logic [11:0]      addr_cnt;
   logic [11:0]      req_addr;
   logic [12:0]      remaining;
   logic [12:0]      len_q;
   logic [12:0]      pop_cnt;
   logic [12:0]      pop_cnt_nxt;
   logic [CNT_W-1:0] credits;
   logic [CNT_W-1:0] credits_ret;
   logic             cmd_fire;
   logic             wd_fire;
   logic             issue;
   logic             load_req;
   logic             req_accept;

   logic             pop;
   logic             head_free;
   logic             load_mem;
   logic             load_bypass;
   logic             mem_wr;
   logic [31:0]      fifo_mem [MAX_OUTST];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] fifo_cnt;

   assign s_ready     = reset_n;
   assign req_accept  = m_valid && m_ready;
   assign load_req    = wd_fire || issue;
   assign req_addr    = cmd_fire ? cmd_addr : addr_cnt;
   assign credits_ret = credits + CNT_W'(pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != IDLE);
         done  <= (state_nxt == DONE);
      end
   end

   // The first read is issued in the command cycle itself so m_valid rises one cycle later.
   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      wd_ready  = 1'b0;
      cmd_fire  = 1'b0;
      wd_fire   = 1'b0;
      issue     = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               cmd_fire = 1'b1;
               if (cmd_len == '0) begin
                  state_nxt = DONE;
               end else if (cmd_write) begin
                  state_nxt = WRITE;
               end else begin
                  state_nxt = READ;
                  issue     = 1'b1;
               end
            end
         end
         WRITE: begin
            wd_ready = (remaining != '0) && (!m_valid || m_ready);
            wd_fire  = wd_ready && wd_valid;
            if (req_accept && (remaining == '0)) state_nxt = DONE;
         end
         READ: begin
            issue = (remaining != '0) && (credits != '0) && (!m_valid || m_ready);
            if (req_accept && (remaining == '0)) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (credits_ret == CRED_MAX) state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_valid   <= 1'b0;
         m_we      <= 1'b0;
         m_addr    <= '0;
         m_data    <= '0;
         addr_cnt  <= '0;
         remaining <= '0;
         len_q     <= '0;
         credits   <= CRED_MAX;
      end else begin
         if (load_req) begin
            m_valid <= 1'b1;
            m_we    <= wd_fire;
            m_addr  <= req_addr;
            m_data  <= wd_fire ? wd_data : 32'h0;
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end
         if (cmd_fire) begin
            len_q     <= cmd_len;
            addr_cnt  <= issue ? cmd_addr + 12'd1 : cmd_addr;
            remaining <= issue ? cmd_len - 13'd1 : cmd_len;
         end else if (load_req) begin
            addr_cnt  <= addr_cnt + 12'd1;
            remaining <= remaining - 13'd1;
         end
         credits <= credits - CNT_W'(issue) + CNT_W'(pop);
      end
   end

   // Head register refills from storage first; an empty FIFO lets s_data go straight to the head.
   assign pop         = rd_valid && rd_ready;
   assign head_free   = !rd_valid || pop;
   assign load_mem    = head_free && (fifo_cnt != '0);
   assign load_bypass = head_free && (fifo_cnt == '0) && s_valid;
   assign mem_wr      = s_valid && !load_bypass;
   assign pop_cnt_nxt = pop_cnt + 13'(pop);

   always_ff @(posedge clk) begin
      if (mem_wr) fifo_mem[wr_ptr] <= s_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         rd_last  <= 1'b0;
         pop_cnt  <= '0;
      end else begin
         if (mem_wr) wr_ptr <= wr_ptr + PTR_W'(1);
         if (load_mem) rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_cnt <= fifo_cnt + CNT_W'(mem_wr) - CNT_W'(load_mem);
         if (load_mem || load_bypass) begin
            rd_valid <= 1'b1;
            rd_data  <= load_mem ? fifo_mem[rd_ptr] : s_data;
            rd_last  <= (pop_cnt_nxt == len_q - 13'd1);
         end else if (pop) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
         end
         if (cmd_fire) pop_cnt <= '0;
         else          pop_cnt <= pop_cnt_nxt;
      end
   end

`ifndef SYNTHESIS
   fifo_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(mem_wr && !load_mem && (fifo_cnt == CRED_MAX)));
`endif

`ifdef MEM_BURST_ADDR_CHECK_EN
   // Issue order equals response order, so a plain FIFO of issued addresses suffices.
   logic [11:0]      exp_mem [MAX_OUTST];
   logic [PTR_W-1:0] exp_wr_ptr;
   logic [PTR_W-1:0] exp_rd_ptr;
   logic [CNT_W-1:0] exp_cnt;
   logic             err_q;

   always_ff @(posedge clk) begin
      if (issue) exp_mem[exp_wr_ptr] <= req_addr;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         exp_wr_ptr <= '0;
         exp_rd_ptr <= '0;
         exp_cnt    <= '0;
         err_q      <= 1'b0;
      end else begin
         if (issue) exp_wr_ptr <= exp_wr_ptr + PTR_W'(1);
         if (s_valid) exp_rd_ptr <= exp_rd_ptr + PTR_W'(1);
         exp_cnt <= exp_cnt + CNT_W'(issue) - CNT_W'(s_valid);
         if (s_valid && ((exp_cnt == '0) || (s_addr != exp_mem[exp_rd_ptr]))) err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   logic unused_s_addr;
   assign unused_s_addr = ^s_addr;
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_burst_initiator.sv
// Directed bench for mem_burst_initiator: per-cycle vector table plus hand-written
// read sequences driven through a two-cycle-latency memory responder.
module tb_mem_burst_initiator;

   localparam int MAX_OUTST = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [11:0] cmd_addr;
   logic [12:0] cmd_len;
   logic        wd_valid, wd_ready;
   logic [31:0] wd_data;
   logic        rd_valid, rd_ready, rd_last;
   logic [31:0] rd_data;
   logic [11:0] m_addr;
   logic [31:0] m_data;
   logic        m_we, m_valid, m_ready;
   logic [11:0] s_addr;
   logic [31:0] s_data;
   logic        s_valid, s_ready;
   logic        busy, done, err;

   always #5 clk = ~clk;

   mem_burst_initiator #(.MAX_OUTST(MAX_OUTST)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .m_addr(m_addr), .m_data(m_data), .m_we(m_we), .m_valid(m_valid), .m_ready(m_ready),
      .s_addr(s_addr), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .busy(busy), .done(done), .err(err)
   );

   typedef struct {
      logic        cv, cw;
      logic [11:0] ca;
      logic [12:0] cl;
      logic        wv;
      logic [31:0] wd;
      logic        rr, mr, sv;
      logic [31:0] sd;
      logic [11:0] sa;
      logic        e_mv, e_mwe;
      logic [11:0] e_ma;
      logic [31:0] e_md;
      logic        e_rv;
      logic [31:0] e_rd;
      logic        e_rl, e_busy, e_done, e_crdy;
   } vec_t;

   vec_t vecs[$];
   int n_vec = 0;
   int n_miss = 0;

   logic        resp_v_a, resp_v_b, corrupt;
   logic [11:0] resp_a_a, resp_a_b;
   logic [11:0] exp_base;
   int          exp_len, acc_cnt, pop_cnt, cyc;

   function automatic vec_t mk(input logic cv, cw, input logic [11:0] ca, input logic [12:0] cl,
                               input logic wv, input logic [31:0] wd, input logic rr, mr, sv,
                               input logic [31:0] sd, input logic [11:0] sa,
                               input logic emv, emwe, input logic [11:0] ema, input logic [31:0] emd,
                               input logic erv, input logic [31:0] erd, input logic erl, eb, ed, ecr);
      vec_t v;
      v.cv = cv; v.cw = cw; v.ca = ca; v.cl = cl; v.wv = wv; v.wd = wd;
      v.rr = rr; v.mr = mr; v.sv = sv; v.sd = sd; v.sa = sa;
      v.e_mv = emv; v.e_mwe = emwe; v.e_ma = ema; v.e_md = emd;
      v.e_rv = erv; v.e_rd = erd; v.e_rl = erl; v.e_busy = eb; v.e_done = ed; v.e_crdy = ecr;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      cmd_valid = v.cv; cmd_write = v.cw; cmd_addr = v.ca; cmd_len = v.cl;
      wd_valid = v.wv; wd_data = v.wd; rd_ready = v.rr; m_ready = v.mr;
      s_valid = v.sv; s_data = v.sd; s_addr = v.sa;
      @(posedge clk); #1;
   endtask

   task automatic checkOutput(input int idx, input vec_t v);
      logic bad;
      bad = (m_valid !== v.e_mv) || (v.e_mv && ((m_we !== v.e_mwe) || (m_addr !== v.e_ma))) ||
            (v.e_mv && v.e_mwe && (m_data !== v.e_md)) || (rd_valid !== v.e_rv) ||
            (v.e_rv && (rd_data !== v.e_rd)) || (rd_last !== v.e_rl) || (busy !== v.e_busy) ||
            (done !== v.e_done) || (cmd_ready !== v.e_crdy);
      n_vec++;
      if (bad) begin
         n_miss++;
         $display("[TB] FAIL vec[%0d]: got mv=%b we=%b addr=%h data=%h rv=%b rdata=%h last=%b busy=%b done=%b crdy=%b; expected mv=%b we=%b addr=%h data=%h rv=%b rdata=%h last=%b busy=%b done=%b crdy=%b",
                  idx, m_valid, m_we, m_addr, m_data, rd_valid, rd_data, rd_last, busy, done, cmd_ready,
                  v.e_mv, v.e_mwe, v.e_ma, v.e_md, v.e_rv, v.e_rd, v.e_rl, v.e_busy, v.e_done, v.e_crdy);
      end
   endtask

   task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // One read-side cycle: memory answers each accepted request two cycles later with data D000_0xxx.
   task automatic stepRead(input logic rr);
      logic        accept, popped;
      logic [11:0] acc_addr, exp_addr;
      rd_ready = rr;
      m_ready  = 1'b1;
      s_valid  = resp_v_a;
      s_addr   = corrupt ? 12'h123 : resp_a_a;
      s_data   = 32'hD000_0000 | {20'h0, resp_a_a};
      accept   = m_valid && !m_we;
      acc_addr = m_addr;
      popped   = rd_valid && rr;
      if (accept) begin
         exp_addr = exp_base + acc_cnt[11:0];
         checkVal("req_addr", {20'h0, acc_addr}, {20'h0, exp_addr});
         acc_cnt++;
      end
      if (popped) begin
         exp_addr = exp_base + pop_cnt[11:0];
         checkVal("rd_data", rd_data, 32'hD000_0000 | {20'h0, exp_addr});
         checkVal("rd_last", {31'h0, rd_last}, {31'h0, (pop_cnt == exp_len - 1)});
         pop_cnt++;
      end
      @(posedge clk); #1;
      resp_v_a = resp_v_b; resp_a_a = resp_a_b;
      resp_v_b = accept;   resp_a_b = acc_addr;
   endtask

   task automatic startRead(input logic [11:0] addr, input int len, input logic rr);
      exp_base = addr; exp_len = len; acc_cnt = 0; pop_cnt = 0;
      resp_v_a = 1'b0; resp_v_b = 1'b0; resp_a_a = '0; resp_a_b = '0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = 13'(len);
      stepRead(rr);
      cmd_valid = 1'b0;
   endtask

   task automatic runToDone(input string name);
      cyc = 0;
      while (!done && cyc < 200) begin
         stepRead(1'b1);
         cyc++;
      end
      checkVal(name, {31'h0, done}, 32'h1);
   endtask

   initial begin
      reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b0; m_ready = 1'b0;
      s_valid = 1'b0; s_data = '0; s_addr = '0; corrupt = 1'b0;
      resp_v_a = 1'b0; resp_v_b = 1'b0; resp_a_a = '0; resp_a_b = '0;
      exp_base = '0; exp_len = 0; acc_cnt = 0; pop_cnt = 0;

      // len=0, write 0x010 x4, write with m_ready 1,0,0,1 stall, read 0xFFE x4 with wrap
      vecs.push_back(mk(1,0,12'h100,13'd0, 0,0, 1,1, 0,0,0, 0,0,0,0, 0,0,0, 1,1,0));
      vecs.push_back(mk(0,0,0,0, 0,0, 1,1, 0,0,0, 0,0,0,0, 0,0,0, 0,0,1));
      vecs.push_back(mk(1,1,12'h010,13'd4, 0,0, 1,1, 0,0,0, 0,0,0,0, 0,0,0, 1,0,0));
      vecs.push_back(mk(0,0,0,0, 1,32'hA0, 1,1, 0,0,0, 1,1,12'h010,32'hA0, 0,0,0, 1,0,0));
      vecs.push_back(mk(0,0,0,0, 1,32'hA1, 1,1, 0,0,0, 1,1,12'h011,32'hA1, 0,0,0, 1,0,0));
      vecs.push_back(mk(0,0,0,0, 1,32'hA2, 1,1, 0,0,0, 1,1,12'h012,32'hA2, 0,0,0, 1,0,0));
      vecs.push_back(mk(0,0,0,0, 1,32'hA3, 1,1, 0,0,0, 1,1,12'h013,32'hA3, 0,0,0, 1,0,0));
      vecs.push_back(mk(0,0,0,0, 0,0, 1,1, 0,0,0, 0,0,0,0, 0,0,0, 1,1,0));
      vecs.push_back(mk(0,0,0,0, 0,0, 1,1, 0,0,0, 0,0,0,0, 0,0,0, 0,0,1));
      vecs.push_back(mk(1,1,12'h200,13'd3, 0,0, 1,1, 0,0,0, 0,0,0,0, 0,0,0, 1,0,0));
      vecs.push_back(mk(0,0,0,0, 1,32'hB0, 1,1, 0,0,0, 1,1,12'h200,32'hB0, 0,0,0, 1,0,0));
      vecs.push_back(mk(0,0,0,0, 1,32'hB1, 1,1, 0,0,0, 1,1,12'h201,32'hB1, 0,0,0, 1,0,0));
      vecs.push_back(mk(0,0,0,0, 1,32'hB2, 1,0, 0,0,0, 1,1,12'h201,32'hB1, 0,0,0, 1,0,0));
      vecs.push_back(mk(0,0,0,0, 1,32'hB2, 1,0, 0,0,0, 1,1,12'h201,32'hB1, 0,0,0, 1,0,0));
      vecs.push_back(mk(0,0,0,0, 1,32'hB2, 1,1, 0,0,0, 1,1,12'h202,32'hB2, 0,0,0, 1,0,0));
      vecs.push_back(mk(0,0,0,0, 0,0, 1,1, 0,0,0, 0,0,0,0, 0,0,0, 1,1,0));
      vecs.push_back(mk(0,0,0,0, 0,0, 1,1, 0,0,0, 0,0,0,0, 0,0,0, 0,0,1));
      vecs.push_back(mk(1,0,12'hFFE,13'd4, 0,0, 1,1, 0,0,0, 1,0,12'hFFE,0, 0,0,0, 1,0,0));
      vecs.push_back(mk(0,0,0,0, 0,0, 1,1, 0,0,0, 1,0,12'hFFF,0, 0,0,0, 1,0,0));
      vecs.push_back(mk(0,0,0,0, 0,0, 1,1, 0,0,0, 1,0,12'h000,0, 0,0,0, 1,0,0));
      vecs.push_back(mk(0,0,0,0, 0,0, 1,1, 1,32'hC0DE_0000,12'hFFE, 1,0,12'h001,0, 1,32'hC0DE_0000,0, 1,0,0));
      vecs.push_back(mk(0,0,0,0, 0,0, 1,1, 1,32'hC0DE_0001,12'hFFF, 0,0,0,0, 1,32'hC0DE_0001,0, 1,0,0));
      vecs.push_back(mk(0,0,0,0, 0,0, 1,1, 1,32'hC0DE_0002,12'h000, 0,0,0,0, 1,32'hC0DE_0002,0, 1,0,0));
      vecs.push_back(mk(0,0,0,0, 0,0, 1,1, 1,32'hC0DE_0003,12'h001, 0,0,0,0, 1,32'hC0DE_0003,1, 1,0,0));
      vecs.push_back(mk(0,0,0,0, 0,0, 1,1, 0,0,0, 0,0,0,0, 0,0,0, 1,1,0));
      vecs.push_back(mk(0,0,0,0, 0,0, 1,1, 0,0,0, 0,0,0,0, 0,0,0, 0,0,1));

      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      #1;
      checkVal("reset_ctrl", {25'h0, m_valid, m_we, rd_valid, rd_last, busy, done, err},
               32'h0);
      checkVal("reset_cmd_ready", {31'h0, cmd_ready}, 32'h1);
      checkVal("reset_m_addr", {20'h0, m_addr}, 32'h0);
      checkVal("reset_m_data", m_data, 32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput(i, vecs[i]);
      end
      s_valid = 1'b0; wd_valid = 1'b0;

      // Credit limit: rd_ready held low caps issue at MAX_OUTST, then releasing it finishes the burst.
      startRead(12'h300, 16, 1'b0);
      for (int i = 0; i < 12; i++) stepRead(1'b0);
      checkVal("credit_issue_count", 32'(acc_cnt), 32'(MAX_OUTST));
      checkVal("credit_stall_m_valid", {31'h0, m_valid}, 32'h0);
      runToDone("credit_done");
      checkVal("credit_pop_count", 32'(pop_cnt), 32'd16);
      stepRead(1'b1);
      checkVal("credit_back_idle", {31'h0, cmd_ready}, 32'h1);

      // Asynchronous reset with two reads outstanding, then a clean len=1 read.
      startRead(12'h010, 8, 1'b1);
      stepRead(1'b1);
      stepRead(1'b1);
      checkVal("rst_outstanding", 32'(acc_cnt), 32'd2);
      reset_n = 1'b0;
      #1;
      checkVal("rst_mid_ctrl", {25'h0, m_valid, m_we, rd_valid, rd_last, busy, done, err}, 32'h0);
      checkVal("rst_mid_m_addr", {20'h0, m_addr}, 32'h0);
      checkVal("rst_mid_rd_data", rd_data, 32'h0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      startRead(12'h010, 1, 1'b1);
      runToDone("post_rst_done");
      checkVal("post_rst_pop_count", 32'(pop_cnt), 32'd1);
      stepRead(1'b1);

`ifdef MEM_BURST_ADDR_CHECK_EN
      corrupt = 1'b1;
      startRead(12'h010, 1, 1'b1);
      runToDone("addr_err_done");
      corrupt = 1'b0;
      checkVal("addr_err_set", {31'h0, err}, 32'h1);
      stepRead(1'b1);
      stepRead(1'b1);
      checkVal("addr_err_sticky", {31'h0, err}, 32'h1);
`else
      checkVal("err_tied_low", {31'h0, err}, 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
